tib_feeder: RTL and testbench

//  Initiator/client side of the dictionary memory pool (pool). Accepts a byte stream, skips leading

---
 rtl/tib_feeder_pkg.sv | 33 +++
 rtl/tib_feeder.sv | 197 +++++++++++++++++++
 tb/tb_tib_feeder.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tib_feeder_pkg.sv
// Shared definitions for the TIB feeder: pool op codes, pool widths, blank characters
// and the feeder FSM states.
package tib_feeder_pkg;

    localparam int unsigned PoolAsz = 17;
    localparam int unsigned PoolDsz = 8;

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpR1   = 3'd1,
        OpW1   = 3'd2,
        OpFind = 3'd3
    } pool_op_e;

    localparam logic [7:0] ChSpace = 8'h20;
    localparam logic [7:0] ChCr    = 8'h0D;
    localparam logic [7:0] ChLf    = 8'h0A;

    typedef enum logic [2:0] {
        StSkip,
        StCopy,
        StTerm,
        StFind,
        StGrd,
        StWait,
        StDone
    } tib_state_e;

    function automatic logic is_blank(input logic [7:0] b);
        return (b == ChSpace) || (b == ChCr) || (b == ChLf);
    endfunction

endpackage

// File: rtl/tib_feeder.sv
// Copies one blank-delimited token from a byte stream into the pool's TIB, NUL-terminates
// it, issues FIND on it and reports the match address (or a timeout).
module tib_feeder
    import tib_feeder_pkg::*;
#(
    parameter int unsigned ASZ    = PoolAsz,
    parameter int unsigned DSZ    = PoolDsz,
    parameter int unsigned TIB    = 'h11,
    parameter int unsigned MAXLEN = 31,
    parameter int unsigned TMO    = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_vld,
    input  logic [7:0]     s_dat,
    output logic           s_rdy,
    output pool_op_e       op,
    output logic [ASZ-1:0] ai,
    output logic [DSZ-1:0] vi,
    output logic           we,
    input  logic           bsy,
    input  logic [ASZ-1:0] ao,
    output logic           done,
    output logic           found,
    output logic [ASZ-1:0] waddr,
    output logic [5:0]     tok_len,
    output logic           trunc,
    output logic           err
);

    localparam int unsigned    TW      = $clog2(TMO + 1);
    localparam logic [ASZ-1:0] TibAddr = ASZ'(TIB);
    localparam logic [5:0]     MaxLen  = 6'(MAXLEN);

    if ((longint'(TIB) + longint'(MAXLEN) >= (longint'(1) << ASZ)) || (MAXLEN > 63))
    begin : g_bad_param
        $error("tib_feeder: TIB+MAXLEN must fit in the pool address space");
    end

    tib_state_e     state_q, state_d;
    logic [5:0]     len_q, len_d;
    logic           trunc_q, trunc_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           s_rdy_q, s_rdy_d;
    pool_op_e       op_q, op_d;
    logic [ASZ-1:0] ai_q, ai_d;
    logic [DSZ-1:0] vi_q, vi_d;
    logic           we_q, we_d;
    logic           done_q, done_d;
    logic           found_q, found_d;
    logic [ASZ-1:0] waddr_q, waddr_d;
    logic [5:0]     tok_len_q, tok_len_d;
    logic           res_trunc_q, res_trunc_d;
    logic           err_q, err_d;
    logic           accept;

    assign accept = s_vld & s_rdy_q;

    // Pool outputs are decoded from the transition being taken, so they show up registered
    // in the cycle the FSM enters the matching state.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        timer_d     = timer_q;
        op_d        = OpNop;
        ai_d        = '0;
        vi_d        = '0;
        we_d        = 1'b0;
        done_d      = 1'b0;
        found_d     = found_q;
        waddr_d     = waddr_q;
        tok_len_d   = tok_len_q;
        res_trunc_d = res_trunc_q;
        err_d       = err_q;
        unique case (state_q)
            StSkip: begin
                if (accept && !is_blank(s_dat)) begin
                    op_d    = OpW1;
                    we_d    = 1'b1;
                    ai_d    = TibAddr;
                    vi_d    = DSZ'(s_dat);
                    len_d   = 6'd1;
                    state_d = StCopy;
                end
            end
            StCopy: begin
                if (accept) begin
                    if (is_blank(s_dat)) begin
                        op_d    = OpW1;
                        we_d    = 1'b1;
                        ai_d    = TibAddr + ASZ'(len_q);
                        state_d = StTerm;
                    end else if (len_q < MaxLen) begin
                        op_d  = OpW1;
                        we_d  = 1'b1;
                        ai_d  = TibAddr + ASZ'(len_q);
                        vi_d  = DSZ'(s_dat);
                        len_d = len_q + 6'd1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
            end
            StTerm: begin
                op_d    = OpFind;
                ai_d    = TibAddr;
                state_d = StFind;
            end
            StFind: begin
                timer_d = '0;
                state_d = StGrd;
            end
            StGrd: begin
                // The guard cycle counts toward the FIND budget.
                timer_d = timer_q + 1'b1;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (!bsy) begin
                    done_d      = 1'b1;
                    found_d     = (ao != '0);
                    waddr_d     = ao;
                    err_d       = 1'b0;
                    tok_len_d   = len_q;
                    res_trunc_d = trunc_q;
                    state_d     = StDone;
                end else if (timer_q == TW'(TMO - 1)) begin
                    done_d      = 1'b1;
                    found_d     = 1'b0;
                    waddr_d     = '0;
                    err_d       = 1'b1;
                    tok_len_d   = len_q;
                    res_trunc_d = trunc_q;
                    state_d     = StDone;
                end
            end
            StDone: begin
                len_d   = '0;
                trunc_d = 1'b0;
                state_d = StSkip;
            end
            default: state_d = StSkip;
        endcase
        s_rdy_d = (state_d == StSkip) || (state_d == StCopy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSkip;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            timer_q     <= '0;
            s_rdy_q     <= 1'b0;
            op_q        <= OpNop;
            ai_q        <= '0;
            vi_q        <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            waddr_q     <= '0;
            tok_len_q   <= '0;
            res_trunc_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            timer_q     <= timer_d;
            s_rdy_q     <= s_rdy_d;
            op_q        <= op_d;
            ai_q        <= ai_d;
            vi_q        <= vi_d;
            we_q        <= we_d;
            done_q      <= done_d;
            found_q     <= found_d;
            waddr_q     <= waddr_d;
            tok_len_q   <= tok_len_d;
            res_trunc_q <= res_trunc_d;
            err_q       <= err_d;
        end
    end

    assign s_rdy   = s_rdy_q;
    assign op      = op_q;
    assign ai      = ai_q;
    assign vi      = vi_q;
    assign we      = we_q;
    assign done    = done_q;
    assign found   = found_q;
    assign waddr   = waddr_q;
    assign tok_len = tok_len_q;
    assign trunc   = res_trunc_q;
    assign err     = err_q;

endmodule

// File: tb/tb_tib_feeder.sv
// Bench for tib_feeder: a behavioural pool answers FIND, and expected TIB writes and
// lookup results are derived from the token rules applied to each byte stream.
module tb_tib_feeder;
    import tib_feeder_pkg::*;

    localparam int unsigned ASZ    = 17;
    localparam int unsigned TIB    = 'h11;
    localparam int unsigned MAXLEN = 31;
    localparam int unsigned TMO    = 1024;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_vld = 1'b0;
    logic [7:0]     s_dat = '0;
    logic           s_rdy;
    pool_op_e       op;
    logic [ASZ-1:0] ai;
    logic [7:0]     vi;
    logic           we;
    logic           bsy = 1'b0;
    logic [ASZ-1:0] ao = '0;
    logic           done, found, trunc, err;
    logic [ASZ-1:0] waddr;
    logic [5:0]     tok_len;

    tib_feeder #(.ASZ(ASZ), .DSZ(8), .TIB(TIB), .MAXLEN(MAXLEN), .TMO(TMO)) u_dut (
        .clk(clk), .rst(rst), .s_vld(s_vld), .s_dat(s_dat), .s_rdy(s_rdy),
        .op(op), .ai(ai), .vi(vi), .we(we), .bsy(bsy), .ao(ao),
        .done(done), .found(found), .waddr(waddr), .tok_len(tok_len),
        .trunc(trunc), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pool model and bus monitor, evaluated mid-cycle.
    logic [ASZ-1:0] wr_addr_q[$];
    logic [7:0]     wr_data_q[$];
    int             find_cnt = 0, find_cyc = 0, done_cnt = 0, done_cyc = 0, we_bad = 0;
    logic [ASZ-1:0] find_addr = '0;
    logic           r_found = 0, r_trunc = 0, r_err = 0;
    logic [ASZ-1:0] r_waddr = '0;
    logic [5:0]     r_len = '0;
    int             bsy_rem = 0;
    int             bsy_len = 3;
    bit             bsy_stuck = 0;
    logic [ASZ-1:0] ao_val = '0;

    always @(negedge clk) begin
        if (we !== (op == OpW1)) we_bad++;
        if (op == OpW1) begin
            wr_addr_q.push_back(ai);
            wr_data_q.push_back(vi);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            r_found  = found;
            r_waddr  = waddr;
            r_len    = tok_len;
            r_trunc  = trunc;
            r_err    = err;
        end
        if (op == OpFind) begin
            find_cnt++;
            find_cyc  = cyc;
            find_addr = ai;
            bsy       = 1'b1;
            bsy_rem   = bsy_len;
        end else if (bsy && !bsy_stuck) begin
            if (bsy_rem <= 1) begin
                bsy = 1'b0;
                ao  = ao_val;
            end else begin
                bsy_rem--;
            end
        end
    end

    // Expected outcome of the current stream.
    logic [7:0]     stream[$];
    logic [ASZ-1:0] exp_addr[$];
    logic [7:0]     exp_data[$];
    int             exp_len;
    bit             exp_trunc;
    int             wbase, fbase, dbase, webase;

    function automatic bit tb_blank(input logic [7:0] b);
        return b == 8'h20 || b == 8'h0D || b == 8'h0A;
    endfunction

    function automatic logic [7:0] rand_char();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (tb_blank(b));
        return b;
    endfunction

    task automatic build_expect();
        bit started = 0, ended = 0;
        int n = 0;
        exp_addr.delete();
        exp_data.delete();
        foreach (stream[i]) begin
            if (ended) continue;
            if (tb_blank(stream[i])) begin
                if (started) ended = 1;
            end else begin
                started = 1;
                if (n < MAXLEN) begin
                    exp_addr.push_back(ASZ'(TIB + n));
                    exp_data.push_back(stream[i]);
                end
                n++;
            end
        end
        exp_len   = (n > MAXLEN) ? MAXLEN : n;
        exp_trunc = (n > MAXLEN);
        if (ended) begin
            exp_addr.push_back(ASZ'(TIB + exp_len));
            exp_data.push_back(8'h00);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte's accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_vld = 1'b1;
        s_dat = b;
        @(negedge clk);
        while (s_rdy !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (s_rdy !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL byte_accept: s_rdy=%b required 1 within 3000 cycles", s_rdy);
        end
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        s_dat = '0;
    endtask

    task automatic run_stream(input int gap, input bit wait_done);
        int n = 0;
        wbase  = wr_addr_q.size();
        fbase  = find_cnt;
        dbase  = done_cnt;
        webase = we_bad;
        build_expect();
        foreach (stream[i]) begin
            send_byte(stream[i]);
            repeat (gap) @(posedge clk);
            #0;
        end
        if (wait_done) begin
            while (done_cnt == dbase && n < 4000) begin
                @(negedge clk);
                n++;
            end
            if (done_cnt == dbase) begin
                total++;
                bad++;
                $display("FAIL done_wait: done_cnt=%0d required %0d", done_cnt, dbase + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input string s);
        stream.delete();
        for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({op, ai, vi, we, s_rdy} !== '0) begin
            bad++;
            $display("FAIL reset_pool: op=%0d ai=%h vi=%h we=%b s_rdy=%b required all 0",
                     op, ai, vi, we, s_rdy);
        end
        total++;
        if ({done, found, waddr, tok_len, trunc, err} !== '0) begin
            bad++;
            $display("FAIL reset_result: done=%b found=%b waddr=%h len=%0d trunc=%b err=%b required 0",
                     done, found, waddr, tok_len, trunc, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (s_rdy !== 1'b1) begin
            bad++;
            $display("FAIL skip_rdy: s_rdy=%b required 1", s_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_found();
        load(" abc ");
        ao_val  = 'h40;
        bsy_len = 3;
        run_stream(0, 1);
        total++;
        if (wr_addr_q.size() - wbase != 4) begin
            bad++;
            $display("FAIL found_nwr: writes=%0d required 4", wr_addr_q.size() - wbase);
        end
        for (int i = 0; i < exp_addr.size() && wbase + i < wr_addr_q.size(); i++) begin
            total++;
            if (wr_addr_q[wbase+i] !== exp_addr[i] || wr_data_q[wbase+i] !== exp_data[i]) begin
                bad++;
                $display("FAIL found_wr%0d: got %h=%h required %h=%h", i,
                         wr_addr_q[wbase+i], wr_data_q[wbase+i], exp_addr[i], exp_data[i]);
            end
        end
        total++;
        if (find_cnt - fbase != 1 || find_addr !== ASZ'(TIB)) begin
            bad++;
            $display("FAIL found_find: finds=%0d ai=%h required 1 at %h",
                     find_cnt - fbase, find_addr, TIB);
        end
        total++;
        if ({r_found, r_waddr, r_len, r_trunc, r_err} !== {1'b1, 17'h40, 6'd3, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL found_res: found=%b waddr=%h len=%0d trunc=%b err=%b required 1 40 3 0 0",
                     r_found, r_waddr, r_len, r_trunc, r_err);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (done_cnt - dbase != 1 || we_bad != webase) begin
            bad++;
            $display("FAIL found_pulse: done_pulses=%0d we_errs=%0d required 1 0",
                     done_cnt - dbase, we_bad - webase);
        end
    endtask

    task automatic test_not_found();
        load("zz\r");
        ao_val  = '0;
        bsy_len = 1;
        run_stream(0, 1);
        total++;
        if (wr_addr_q.size() - wbase != 3 || wr_addr_q[wbase+2] !== 17'h13
            || wr_data_q[wbase+2] !== 8'h00) begin
            bad++;
            $display("FAIL nf_wr: writes=%0d last=%h=%h required 3 last 13=00",
                     wr_addr_q.size() - wbase, wr_addr_q[$], wr_data_q[$]);
        end
        total++;
        if ({r_found, r_waddr, r_len, r_err} !== {1'b0, 17'h0, 6'd2, 1'b0}) begin
            bad++;
            $display("FAIL nf_res: found=%b waddr=%h len=%0d err=%b required 0 0 2 0",
                     r_found, r_waddr, r_len, r_err);
        end
    endtask

    task automatic test_trunc();
        stream.delete();
        repeat (40) stream.push_back("x");
        stream.push_back(" ");
        ao_val  = 'h77;
        bsy_len = 2;
        run_stream(0, 1);
        total++;
        if (wr_addr_q.size() - wbase != 32 || wr_addr_q[$] !== 17'h30 || wr_data_q[$] !== 8'h00)
        begin
            bad++;
            $display("FAIL trunc_wr: writes=%0d last=%h=%h required 32 last 30=00",
                     wr_addr_q.size() - wbase, wr_addr_q[$], wr_data_q[$]);
        end
        for (int i = 0; i < 31 && wbase + i < wr_addr_q.size(); i++) begin
            total++;
            if (wr_addr_q[wbase+i] !== exp_addr[i] || wr_data_q[wbase+i] !== 8'h78) begin
                bad++;
                $display("FAIL trunc_wr%0d: got %h=%h required %h=78", i,
                         wr_addr_q[wbase+i], wr_data_q[wbase+i], exp_addr[i]);
            end
        end
        total++;
        if (r_len !== 6'd31 || r_trunc !== 1'b1 || r_found !== 1'b1) begin
            bad++;
            $display("FAIL trunc_res: len=%0d trunc=%b found=%b required 31 1 1",
                     r_len, r_trunc, r_found);
        end
    endtask

    task automatic test_timeout();
        load("ab ");
        ao_val    = 'h55;
        bsy_len   = 2;
        bsy_stuck = 1;
        run_stream(0, 1);
        bsy_stuck = 0;
        total++;
        if (done_cyc - (find_cyc + 1) != TMO) begin
            bad++;
            $display("FAIL tmo_latency: done %0d cycles after guard, required %0d",
                     done_cyc - (find_cyc + 1), TMO);
        end
        total++;
        if ({r_err, r_found, r_waddr, r_len} !== {1'b1, 1'b0, 17'h0, 6'd2}) begin
            bad++;
            $display("FAIL tmo_res: err=%b found=%b waddr=%h len=%0d required 1 0 0 2",
                     r_err, r_found, r_waddr, r_len);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int base = wr_addr_q.size();
        int fb = find_cnt;
        send_byte("a");
        send_byte("b");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (op !== OpNop) begin
            bad++;
            $display("FAIL rstmid_op_pre: op=%0d required NOP", op);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (op !== OpNop || we !== 1'b0 || s_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_op: op=%0d we=%b s_rdy=%b required NOP 0 0", op, we, s_rdy);
        end
        total++;
        if (wr_addr_q.size() - base != 2 || find_cnt != fb) begin
            bad++;
            $display("FAIL rstmid_abandon: writes=%0d finds=%0d required 2 0",
                     wr_addr_q.size() - base, find_cnt - fb);
        end
        @(posedge clk);
        #1;
        load("cd ");
        ao_val  = 'h22;
        bsy_len = 1;
        run_stream(0, 1);
        total++;
        if (wr_addr_q.size() - wbase != 3
            || {wr_addr_q[wbase], wr_data_q[wbase]} !== {17'h11, 8'h63}
            || {wr_addr_q[wbase+1], wr_data_q[wbase+1]} !== {17'h12, 8'h64}
            || {wr_addr_q[wbase+2], wr_data_q[wbase+2]} !== {17'h13, 8'h00}) begin
            bad++;
            $display("FAIL rstmid_wr: writes=%0d last=%h=%h required 11=63 12=64 13=00",
                     wr_addr_q.size() - wbase, wr_addr_q[$], wr_data_q[$]);
        end
        total++;
        if (r_len !== 6'd2 || r_waddr !== 17'h22) begin
            bad++;
            $display("FAIL rstmid_res: len=%0d waddr=%h required 2 22", r_len, r_waddr);
        end
    endtask

    task automatic test_gaps();
        load("  q\n");
        ao_val  = 'h31;
        bsy_len = 2;
        run_stream(1, 1);
        total++;
        if (wr_addr_q.size() - wbase != 2
            || {wr_addr_q[wbase], wr_data_q[wbase]} !== {17'h11, 8'h71}
            || {wr_addr_q[wbase+1], wr_data_q[wbase+1]} !== {17'h12, 8'h00}) begin
            bad++;
            $display("FAIL gaps_wr: writes=%0d first=%h=%h required 11=71 12=00",
                     wr_addr_q.size() - wbase, wr_addr_q[wbase], wr_data_q[wbase]);
        end
        total++;
        if (r_len !== 6'd1 || r_found !== 1'b1 || we_bad != webase) begin
            bad++;
            $display("FAIL gaps_res: len=%0d found=%b we_errs=%0d required 1 1 0",
                     r_len, r_found, we_bad - webase);
        end
    endtask

    task automatic test_random();
        logic [7:0] blanks[3];
        blanks[0] = 8'h20;
        blanks[1] = 8'h0D;
        blanks[2] = 8'h0A;
        for (int it = 0; it < 12; it++) begin
            int nlead = $urandom_range(0, 3);
            int ntok = $urandom_range(1, 40);
            stream.delete();
            for (int k = 0; k < nlead; k++) stream.push_back(blanks[$urandom_range(0, 2)]);
            for (int k = 0; k < ntok; k++) stream.push_back(rand_char());
            stream.push_back(blanks[$urandom_range(0, 2)]);
            ao_val  = ($urandom_range(0, 3) == 0) ? '0 : ASZ'($urandom_range(1, 'h1FFFF));
            bsy_len = $urandom_range(1, 8);
            run_stream($urandom_range(0, 2), 1);
            total++;
            if (wr_addr_q.size() - wbase != exp_addr.size()) begin
                bad++;
                $display("FAIL rnd%0d_nwr: writes=%0d required %0d", it,
                         wr_addr_q.size() - wbase, exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && wbase + i < wr_addr_q.size(); i++) begin
                total++;
                if (wr_addr_q[wbase+i] !== exp_addr[i] || wr_data_q[wbase+i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL rnd%0d_wr%0d: got %h=%h required %h=%h", it, i,
                             wr_addr_q[wbase+i], wr_data_q[wbase+i], exp_addr[i], exp_data[i]);
                end
            end
            total++;
            if ({r_found, r_waddr, r_len, r_trunc, r_err}
                !== {ao_val != '0, ao_val, 6'(exp_len), exp_trunc, 1'b0}) begin
                bad++;
                $display("FAIL rnd%0d_res: %b %h %0d %b %b required %b %h %0d %b 0", it,
                         r_found, r_waddr, r_len, r_trunc, r_err,
                         ao_val != '0, ao_val, exp_len, exp_trunc);
            end
            total++;
            if (find_cnt - fbase != 1 || done_cnt - dbase != 1 || we_bad != webase) begin
                bad++;
                $display("FAIL rnd%0d_ops: finds=%0d dones=%0d we_errs=%0d required 1 1 0", it,
                         find_cnt - fbase, done_cnt - dbase, we_bad - webase);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_found();
        test_not_found();
        test_trunc();
        test_timeout();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
